// File: rtl/stim_seq_pkg.sv
// ---------------------------------------------------------------
// stim_seq_pkg: shared types/constants for stim_sequencer (rev 1.0)
// ---------------------------------------------------------------
`default_nettype none

package stim_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int IN_LSB             = 0;
  localparam int DEFAULT_MAX_CYCLES = 10000;

  // Observation bit is always the top bit of an opcode word.
  function automatic int obs_bit(input int op_w);
    return op_w - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stim_skid_buf.sv
// ---------------------------------------------------------------
// stim_skid_buf: one-entry capture register for held reads (rev 1.0)
// ---------------------------------------------------------------
`default_nettype none

module stim_skid_buf
  import stim_seq_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         load,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stim_sequencer.sv
// ---------------------------------------------------------------
// stim_sequencer: stimulus RAM replay controller (rev 1.0)
// ---------------------------------------------------------------
`default_nettype none

module stim_sequencer
  import stim_seq_pkg::*;
#(
  parameter int IN_W       = 1,
  parameter int OP_W       = IN_W + 1,
  parameter int ADDR_W     = 10,
  parameter int PC_W       = 32,
  parameter int MAX_CYCLES = DEFAULT_MAX_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              hold,
  input  logic              abort,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [OP_W-1:0]   mem_rdata,
  output logic [IN_W-1:0]   stim_in,
  output logic              stim_obs,
  output logic              stim_valid,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              done,
  output logic              timed_out
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int CYC_W = $clog2(MAX_CYCLES + 1);
  localparam int OBS   = obs_bit(OP_W);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLES - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  len, issued, applied;
  logic [CYC_W-1:0]  cyc;
  logic              rd_pend;

  logic              issue, fire, expire, last, have, start_acc;
  logic              skid_load, skid_pop, skid_flush, skid_valid;
  logic [OP_W-1:0]   skid_dout, word;

  assign have     = skid_valid | rd_pend;
  assign word     = skid_valid ? skid_dout : mem_rdata;
  assign last     = ((applied + CNT_W'(1)) == len);
  assign skid_pop = skid_valid & fire;
  // Leaving RUN for any reason discards a parked word.
  assign skid_flush = (state_nxt != ST_RUN);

  assign mem_en   = issue;
  assign mem_addr = issue ? issued[ADDR_W-1:0] : '0;
  assign busy     = (state == ST_FETCH) || (state == ST_RUN);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    fire      = 1'b0;
    expire    = 1'b0;
    skid_load = 1'b0;
    start_acc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = (cfg_len == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!hold) begin
          issue     = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        expire = (cyc == CYC_LAST);
        if (hold) begin
          skid_load = rd_pend;
        end else begin
          // On budget expiry only the final word may still be applied.
          fire  = have && (!expire || last);
          issue = !expire && (issued < len);
        end
        if ((fire && last) || expire) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
      issue     = 1'b0;
      fire      = 1'b0;
      skid_load = 1'b0;
      start_acc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      len        <= '0;
      issued     <= '0;
      applied    <= '0;
      cyc        <= '0;
      rd_pend    <= 1'b0;
      pc         <= '0;
      stim_in    <= '0;
      stim_obs   <= 1'b0;
      stim_valid <= 1'b0;
      done       <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_pend    <= issue;
      stim_valid <= fire;
      done       <= (state == ST_DONE) && !abort;
      if (abort) begin
        stim_in  <= '0;
        stim_obs <= 1'b0;
      end
      if (start_acc) begin
        len       <= cfg_len;
        issued    <= '0;
        applied   <= '0;
        cyc       <= '0;
        pc        <= '0;
        timed_out <= 1'b0;
      end
      if (issue) begin
        issued <= issued + CNT_W'(1);
      end
      if (fire) begin
        stim_in  <= word[IN_LSB +: IN_W];
        stim_obs <= word[OBS];
        pc       <= pc + PC_W'(1);
        applied  <= applied + CNT_W'(1);
      end
      if (state == ST_RUN && !abort) begin
        cyc <= cyc + CYC_W'(1);
      end
      if (expire && !(fire && last) && !abort) begin
        timed_out <= 1'b1;
      end
    end
  end

  stim_skid_buf #(
    .W (OP_W)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .flush (skid_flush),
    .load  (skid_load),
    .pop   (skid_pop),
    .din   (mem_rdata),
    .dout  (skid_dout),
    .valid (skid_valid)
  );

endmodule

`default_nettype wire

// File: doc/stim_sequencer.md
Name: stim_sequencer

Overview:
- Hardware stimulus replay controller for the concolic flow.
- Fetches packed opcode words from a synchronous stimulus RAM and splits each into a DUT input field and an observation bit.
- Applies one word per cycle to the design under test, with run/hold/abort control, a cycle budget, and a program counter exported for trace logging.
- Sits between the stimulus memory (loaded from data.mem) and the DUT input pins; replaces the free-running generated PC logic.

Parameters:
- IN_W, 1, width of the DUT input field (opcode bits [IN_W-1:0])
- OP_W, IN_W+1, opcode word width; bit OP_W-1 is the observation bit
- ADDR_W, 10, stimulus RAM address width
- PC_W, 32, program counter width
- MAX_CYCLES, 10000, RUN-state cycle budget before forced stop

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; honoured only in IDLE
- cfg_len  in  ADDR_W+1  number of opcode words to apply, sampled on start
- hold  in  1  pause; no fetch or advance while high
- abort  in  1  return to IDLE from any state
- mem_en  out  1  RAM read enable
- mem_addr  out  ADDR_W  RAM read address
- mem_rdata  in  OP_W  RAM data, valid the cycle after mem_en
- stim_in  out  IN_W  DUT input drive
- stim_obs  out  1  DUT __obs drive
- stim_valid  out  1  stim_* carries a newly applied word this cycle
- pc  out  PC_W  count of words applied since start
- busy  out  1  state is FETCH or RUN
- done  out  1  one-cycle pulse on entering DONE
- timed_out  out  1  sticky; set when the budget expires, cleared on the next accepted start

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters and skid buffer cleared.
- Required states:
  - IDLE: on start, latch cfg_len and clear pc, the cycle counter and timed_out. If cfg_len == 0, go to DONE; otherwise go to FETCH.
  - FETCH: issue read of address 0 (mem_en=1); go to RUN the next cycle. hold in FETCH delays the issue.
  - RUN: each cycle with hold=0 and a word returned:
    - Register mem_rdata[IN_W-1:0] into stim_in and mem_rdata[OP_W-1] into stim_obs.
    - Set stim_valid=1 and increment pc.
    - Issue the next read while issued_count < len.
  - RUN exit: after word len-1 is applied, go to DONE the next cycle.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: first word appears on stim_* two cycles after start (FETCH issue, RUN capture). Steady state is one word per cycle.
- Stall / hold:
  - hold=1: mem_en=0, stim_in/stim_obs hold their value, stim_valid=0, pc frozen.
  - A read already in flight when hold rises is captured in a one-entry skid register.
  - That word is applied from the skid register on the first cycle after hold falls; no word is lost or duplicated.
- Outputs while not applying: stim_in and stim_obs keep their last value in RUN/DONE/IDLE. Reset and abort force them to 0.
- Budget:
  - The cycle counter increments every RUN cycle, hold cycles included.
  - On reaching MAX_CYCLES: set timed_out, go to DONE, discard any in-flight or skid word.
  - If the final word is applied on the same cycle the budget expires, completion wins and timed_out stays 0.
- Abort:
  - Highest priority over start, hold and completion.
  - Next cycle: IDLE, stim_* and stim_valid = 0, skid buffer flushed, no done pulse.
  - pc and timed_out keep their values.
- start outside IDLE is ignored. start and abort together: abort wins and the start is dropped.
- Address wrap: mem_addr is the low ADDR_W bits of the issue counter. cfg_len is at most 2^ADDR_W, so no wrap occurs within one run. pc wraps modulo 2^PC_W.

Decomposition:
- Package stim_seq_pkg holds:
  - the state enum (IDLE, FETCH, RUN, DONE);
  - OBS_BIT / IN_LSB field-position constants;
  - the default MAX_CYCLES.
- Sub-module stim_skid_buf: the one-entry capture register with valid flag, load on in-flight-data-during-hold, and pop on resume.

Test Plan:
- Basic replay: load RAM[0..3] = 2'b01,10,11,00; start with cfg_len=4. Expect:
  - stim_valid high on cycles 2–5 after start;
  - (stim_obs, stim_in) = (0,1), (1,0), (1,1), (0,0);
  - pc = 1..4;
  - done pulse on cycle 6.
- Zero length: start with cfg_len=0 → mem_en never asserted, done on cycle 1, pc=0.
- Hold mid-stream: cfg_len=6, hold high for 3 cycles right after word 2 is applied → the in-flight word 3 comes out of skid on resume, all 6 words applied in order, pc=6, no duplicates.
- Timeout: MAX_CYCLES=8, cfg_len=20, hold asserted from the 5th RUN cycle → timed_out=1 and done after 8 RUN cycles; timed_out cleared on the next start.
- Abort: abort during RUN after word 3 → next cycle IDLE, stim_in=0, stim_obs=0, no done pulse, pc=3. A subsequent start replays from address 0.
- Reset mid-run: assert reset during RUN → all outputs 0 next cycle, state IDLE, start accepted afterwards.
